btn_debounce_multi: RTL and testbench
=====================================

// Module: btn_debounce_multi
// PURPOSE
//  N-channel button debouncer/edge detector with optional auto-repeat. Each channel is
//  synchronised, then filtered: it must disagree with its debounced state for STABLE_CNT
//  consecutive en ticks before the state flips. Emits per-channel level, press/release
//  pulses and repeat pulses. Sits between the board push-buttons and the control FSMs,
//  sharing the slow enable tick (en) from the clock-divider block.
// PARAMETERS
//  N_CH           4      number of independent button channels
//  CNT_W          16     width of the debounce and hold counters
//  STABLE_CNT     50000  en ticks of stable disagreement needed to flip state (1..2^CNT_W-1)
//  BTN_ACTIVE_LOW 0      1: a raw btn level of 0 means pressed (inverted before the synchroniser)
//  REPEAT_EN      0      1: enable auto-repeat pulses while a channel is held
//  HOLD_TICKS     500    en ticks held before the first rpt pulse (1..2^CNT_W-1)
//  REPEAT_TICKS   100    en ticks between later rpt pulses (1..2^CNT_W-1)
// PORTS
//  clk      in   1     system clock, all logic on the rising edge
//  rst_n    in   1     asynchronous reset, active low
//  en       in   1     sampling tick; counters advance only when en=1
//  btn      in   N_CH  raw, asynchronous button inputs
//  level    out  N_CH  debounced pressed state
//  press    out  N_CH  1-clk pulse on a debounced 0->1 transition
//  release  out  N_CH  1-clk pulse on a debounced 1->0 transition
//  rpt      out  N_CH  1-clk auto-repeat pulse; always 0 when REPEAT_EN=0
// BEHAVIOUR
//  Reset: rst_n=0 immediately clears the sync flops, counters, level, press, release and rpt.
//   This holds even mid-count. The first clk edge after rst_n rises is a normal cycle.
//  Per channel i (fully independent), s = output of the 2-FF synchroniser on btn[i], clocked every clk:
//   - s==level: debounce counter cnt <= 0, on every clk regardless of en.
//   - s!=level, en=1, cnt<STABLE_CNT-1: cnt <= cnt+1.
//   - s!=level, en=1, cnt==STABLE_CNT-1: level <= s, cnt <= 0.
//     Same edge: press <= s (0->1 flip) or release <= ~s (1->0 flip).
//   - s!=level, en=0: cnt holds.
//  press, release and rpt are registered and high for exactly one clk. Otherwise they are 0.
//  Latency: raw edge -> s is 2 clk. Then STABLE_CNT en ticks, so with en=1 the pulse comes 2+STABLE_CNT clk after the edge.
//  Bounce: any return of s to level before the count completes restarts the count from 0.
//  Auto-repeat (REPEAT_EN=1): hold counter hc and flag first_done, per channel.
//   - level=0: hc <= 0, first_done <= 0.
//   - level=1, en=1: hc increments.
//   - hc==HOLD_TICKS-1 and !first_done: rpt pulse, hc <= 0, first_done <= 1.
//   - hc==REPEAT_TICKS-1 and first_done: rpt pulse, hc <= 0.
//   - hc starts counting on the first en tick after the press edge, so rpt never coincides with press.
//   - If the release flip and an rpt threshold hit on the same edge, release wins and rpt is suppressed.
//  Counters never wrap: they are bounded by the thresholds above.
//  Channels flipping on the same edge produce simultaneous pulses on their own bits.
// TESTING (N_CH=4, STABLE_CNT=4, en=1 unless stated)
//  1 btn[0] 0->1, held 20 clk -> press[0] single pulse 6 clk after edge, level[0]=1; btn[0]->0 -> release[0] 6 clk later.
//  2 btn[1] toggles every 2 clk for 12 clk, then stays 1 -> no pulses during toggling;
//    exactly one press[1], 6 clk after the last edge.
//  3 en high 1 clk in 4 -> press 2+13..16 clk after edge; en held 0 with btn changed -> level, pulses unchanged.
//  4 REPEAT_EN=1, HOLD_TICKS=8, REPEAT_TICKS=3, btn[2] held 30 en ticks after press ->
//    rpt[2] at ticks 8,11,14,17,20,23,26,29; release -> rpt stops, and a new press restarts at 8.
//  5 rst_n pulled low between edges with cnt=3 -> all outputs 0 at once; btn held through reset ->
//    press 6 clk after rst_n rises.
//  6 BTN_ACTIVE_LOW=1, btn[3] 1->0 at the same edge btn[0] 0->1 -> press[3] and press[0] in the same clk, other bits 0.

Source files
------------

// File: rtl/btn_debounce_multi.sv
// -----------------------------------------------------------------------------
// btn_debounce_multi
//   N-channel push-button debouncer with press/release edge pulses and optional
//   auto-repeat. Each raw input is polarity-normalised, passed through a 2-FF
//   synchroniser, then must disagree with its debounced level for STABLE_CNT
//   consecutive en ticks before the level flips.
//
// Ports
//   clk            in   1     system clock, rising edge
//   rst_n          in   1     asynchronous reset, active low
//   en             in   1     sampling tick; counters advance only when en=1
//   btn            in   N_CH  raw asynchronous button inputs
//   level          out  N_CH  debounced pressed state
//   press          out  N_CH  1-clk pulse on a debounced 0->1 flip
//   release_pulse  out  N_CH  1-clk pulse on a debounced 1->0 flip
//                             ('release' is a reserved word in SystemVerilog)
//   rpt            out  N_CH  1-clk auto-repeat pulse while held (0 if REPEAT_EN=0)
// -----------------------------------------------------------------------------
module btn_debounce_multi #(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned STABLE_CNT     = 50000,
    parameter int unsigned BTN_ACTIVE_LOW = 0,
    parameter int unsigned REPEAT_EN      = 0,
    parameter int unsigned HOLD_TICKS     = 500,
    parameter int unsigned REPEAT_TICKS   = 100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] rpt
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    logic [N_CH-1:0]  pressed_c;
    logic [N_CH-1:0]  sync1_q;
    logic [N_CH-1:0]  sync2_q;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] hc_q  [N_CH];
    logic [CNT_W-1:0] hc_d  [N_CH];
    logic [N_CH-1:0]  first_done_q;
    logic [N_CH-1:0]  first_done_d;
    logic [N_CH-1:0]  level_d;
    logic [N_CH-1:0]  press_d;
    logic [N_CH-1:0]  release_d;
    logic [N_CH-1:0]  rpt_d;

    // Invert before the synchroniser so reset (all zeros) always means "not pressed".
    assign pressed_c = (BTN_ACTIVE_LOW != 0) ? ~btn : btn;

    // Debounce and auto-repeat next-state logic, one independent slice per channel.
    always_comb begin
        cnt_d        = cnt_q;
        hc_d         = hc_q;
        first_done_d = first_done_q;
        level_d      = level;
        press_d      = '0;
        release_d    = '0;
        rpt_d        = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (sync2_q[i] == level[i]) begin
                cnt_d[i] = '0;
            end else if (en) begin
                if (cnt_q[i] == STABLE_LAST) begin
                    cnt_d[i]     = '0;
                    level_d[i]   = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end

            // Hold counter only runs from the first en tick after the press edge;
            // a release flip on the same edge wins over any threshold hit.
            if ((REPEAT_EN == 0) || !level[i] || release_d[i]) begin
                hc_d[i]         = '0;
                first_done_d[i] = 1'b0;
            end else if (en) begin
                if (!first_done_q[i] && (hc_q[i] == HOLD_LAST)) begin
                    rpt_d[i]        = 1'b1;
                    hc_d[i]         = '0;
                    first_done_d[i] = 1'b1;
                end else if (first_done_q[i] && (hc_q[i] == REPEAT_LAST)) begin
                    rpt_d[i] = 1'b1;
                    hc_d[i]  = '0;
                end else begin
                    hc_d[i] = hc_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            level         <= '0;
            press         <= '0;
            release_pulse <= '0;
            rpt           <= '0;
            first_done_q  <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= '0;
                hc_q[i]  <= '0;
            end
        end else begin
            sync1_q       <= pressed_c;
            sync2_q       <= sync1_q;
            level         <= level_d;
            press         <= press_d;
            release_pulse <= release_d;
            rpt           <= rpt_d;
            first_done_q  <= first_done_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= cnt_d[i];
                hc_q[i]  <= hc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: instance A is active-high with auto-repeat
// (HOLD 8 / REPEAT 3), instance B is active-low without repeat. A behavioural
// model (delay line + run lengths + held-tick arithmetic) predicts every output.
module tb_btn_debounce_multi;

    localparam int SC = 4;
    localparam int HT = 8;
    localparam int RT = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic [3:0] btn_a = 4'h0;
    logic [3:0] btn_b = 4'hF;
    logic [3:0] lvl_a, prs_a, rel_a, rpt_a;
    logic [3:0] lvl_b, prs_b, rel_b, rpt_b;
    logic [31:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    btn_debounce_multi #(
        .N_CH(4), .CNT_W(16), .STABLE_CNT(SC), .BTN_ACTIVE_LOW(0),
        .REPEAT_EN(1), .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .btn(btn_a),
        .level(lvl_a), .press(prs_a), .release_pulse(rel_a), .rpt(rpt_a)
    );

    btn_debounce_multi #(
        .N_CH(4), .CNT_W(16), .STABLE_CNT(SC), .BTN_ACTIVE_LOW(1),
        .REPEAT_EN(0), .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .btn(btn_b),
        .level(lvl_b), .press(prs_b), .release_pulse(rel_b), .rpt(rpt_b)
    );

    assign obs = {lvl_a, prs_a, rel_a, rpt_a, lvl_b, prs_b, rel_b, rpt_b};

    // ---------------- behavioural model ----------------
    bit m_p1  [2][4];
    bit m_p2  [2][4];
    bit m_lvl [2][4];
    bit m_prs [2][4];
    bit m_rel [2][4];
    bit m_rpt [2][4];
    int m_run [2][4];
    int m_held[2][4];

    function automatic void model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                m_p1[d][c] = 0; m_p2[d][c] = 0; m_lvl[d][c] = 0;
                m_prs[d][c] = 0; m_rel[d][c] = 0; m_rpt[d][c] = 0;
                m_run[d][c] = 0; m_held[d][c] = 0;
            end
        end
    endfunction

    // One clock edge: s is the pressed-ness seen two edges ago; held counts en
    // ticks with the button already debounced-pressed before this edge.
    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                bit s;
                bit was;
                bit raw;
                raw = (d == 0) ? btn_a[c] : ~btn_b[c];
                s = m_p2[d][c];
                m_p2[d][c] = m_p1[d][c];
                m_p1[d][c] = raw;
                was = m_lvl[d][c];
                m_prs[d][c] = 0; m_rel[d][c] = 0; m_rpt[d][c] = 0;
                if (s == was) m_run[d][c] = 0;
                else if (en) begin
                    m_run[d][c]++;
                    if (m_run[d][c] == SC) begin
                        m_lvl[d][c] = s;
                        m_run[d][c] = 0;
                        m_prs[d][c] = s;
                        m_rel[d][c] = !s;
                    end
                end
                if (!was || m_rel[d][c]) m_held[d][c] = 0;
                else if (en) begin
                    m_held[d][c]++;
                    if (d == 0 && (m_held[d][c] == HT ||
                        (m_held[d][c] > HT && (m_held[d][c] - HT) % RT == 0)))
                        m_rpt[d][c] = 1;
                end
            end
        end
    endfunction

    function automatic logic [31:0] exp_all();
        logic [31:0] v;
        v = '0;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                v[(1-d)*16 + 12 + c] = m_lvl[d][c];
                v[(1-d)*16 + 8  + c] = m_prs[d][c];
                v[(1-d)*16 + 4  + c] = m_rel[d][c];
                v[(1-d)*16 + c]      = m_rpt[d][c];
            end
        end
        return v;
    endfunction

    // Advance one clock: model follows the edge, return at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_clear();
        else model_step();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        if (obs !== 32'h0) begin n_errors++; $display("FAIL reset_async got=%h exp=0", obs); end
        n_checks++;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (obs !== 32'h0) begin n_errors++; $display("FAIL reset_hold got=%h exp=0", obs); end
            n_checks++;
        end
        rst_n = 1'b1;
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (obs !== exp_all()) begin n_errors++; $display("FAIL reset_idle got=%h exp=%h", obs, exp_all()); end
            n_checks++;
        end
    endtask

    task automatic test_press_release();
        int pc, np, rc, nr;
        pc = -1; np = 0; rc = -1; nr = 0;
        en = 1'b1;
        btn_a[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (obs !== exp_all()) begin n_errors++; $display("FAIL press_model k=%0d got=%h exp=%h", k, obs, exp_all()); end
            n_checks++;
            if (prs_a[0]) begin np++; if (pc < 0) pc = k; end
        end
        if (pc !== 6 || np !== 1) begin n_errors++; $display("FAIL press_latency got cyc=%0d cnt=%0d exp cyc=6 cnt=1", pc, np); end
        n_checks++;
        if (lvl_a[0] !== 1'b1) begin n_errors++; $display("FAIL press_level got=%b exp=1", lvl_a[0]); end
        n_checks++;
        btn_a[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (obs !== exp_all()) begin n_errors++; $display("FAIL release_model k=%0d got=%h exp=%h", k, obs, exp_all()); end
            n_checks++;
            if (rel_a[0]) begin nr++; if (rc < 0) rc = k; end
        end
        if (rc !== 6 || nr !== 1) begin n_errors++; $display("FAIL release_latency got cyc=%0d cnt=%0d exp cyc=6 cnt=1", rc, nr); end
        n_checks++;
    endtask

    task automatic test_bounce();
        int early, pc, np;
        early = 0; pc = -1; np = 0;
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            btn_a[1] = ((k / 2) % 2) == 0;
            cycle();
            if (obs !== exp_all()) begin n_errors++; $display("FAIL bounce_model k=%0d got=%h exp=%h", k, obs, exp_all()); end
            n_checks++;
            if (prs_a[1] || rel_a[1]) early++;
        end
        btn_a[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            if (obs !== exp_all()) begin n_errors++; $display("FAIL bounce_settle k=%0d got=%h exp=%h", k, obs, exp_all()); end
            n_checks++;
            if (prs_a[1]) begin np++; if (pc < 0) pc = k; end
        end
        if (early !== 0) begin n_errors++; $display("FAIL bounce_quiet got=%0d pulses exp=0", early); end
        n_checks++;
        if (pc !== 6 || np !== 1) begin n_errors++; $display("FAIL bounce_press got cyc=%0d cnt=%0d exp cyc=6 cnt=1", pc, np); end
        n_checks++;
    endtask

    task automatic test_sparse_en();
        int phase, pc, np;
        phase = int'($urandom_range(0, 3));
        pc = -1; np = 0;
        btn_a[2] = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            en = ((k % 4) == phase);
            cycle();
            if (obs !== exp_all()) begin n_errors++; $display("FAIL sparse_model k=%0d got=%h exp=%h", k, obs, exp_all()); end
            n_checks++;
            if (prs_a[2]) begin np++; if (pc < 0) pc = k; end
        end
        if (pc < 15 || pc > 18 || np !== 1) begin n_errors++; $display("FAIL sparse_press got cyc=%0d cnt=%0d exp cyc=15..18 cnt=1", pc, np); end
        n_checks++;
        en = 1'b0;
        btn_a[2] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (lvl_a[2] !== 1'b1 || rel_a[2] !== 1'b0) begin
                n_errors++; $display("FAIL en_low_hold k=%0d got lvl=%b rel=%b exp lvl=1 rel=0", k, lvl_a[2], rel_a[2]);
            end
            n_checks++;
        end
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (obs !== exp_all()) begin n_errors++; $display("FAIL en_resume k=%0d got=%h exp=%h", k, obs, exp_all()); end
            n_checks++;
        end
    endtask

    task automatic test_repeat();
        int q[$];
        int first;
        bit seen;
        en = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            btn_a[2] = 1'b1;
            seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                cycle();
                if (obs !== exp_all()) begin n_errors++; $display("FAIL rpt_wait_press got=%h exp=%h", obs, exp_all()); end
                n_checks++;
                seen = prs_a[2];
            end
            if (!seen) begin n_errors++; $display("FAIL rpt_press_timeout got=none exp=press"); end
            n_checks++;
            q.delete();
            for (int t = 1; t <= 30; t++) begin
                cycle();
                if (obs !== exp_all()) begin n_errors++; $display("FAIL rpt_model t=%0d got=%h exp=%h", t, obs, exp_all()); end
                n_checks++;
                if (rpt_a[2]) q.push_back(t);
            end
            if (q.size() !== 8) begin n_errors++; $display("FAIL rpt_count pass=%0d got=%0d exp=8", pass, q.size()); end
            n_checks++;
            first = (q.size() > 0) ? q[0] : -1;
            if (first !== 8) begin n_errors++; $display("FAIL rpt_first pass=%0d got=%0d exp=8", pass, first); end
            n_checks++;
            for (int i = 1; i < q.size() && i < 8; i++) begin
                if (q[i] !== 8 + 3 * i) begin n_errors++; $display("FAIL rpt_tick i=%0d got=%0d exp=%0d", i, q[i], 8 + 3 * i); end
                n_checks++;
            end
            btn_a[2] = 1'b0;
            seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                cycle();
                if (obs !== exp_all()) begin n_errors++; $display("FAIL rpt_wait_release got=%h exp=%h", obs, exp_all()); end
                n_checks++;
                seen = rel_a[2];
                if (seen && rpt_a[2] !== 1'b0) begin n_errors++; $display("FAIL rpt_on_release got=1 exp=0"); end
                if (seen) n_checks++;
            end
            if (!seen) begin n_errors++; $display("FAIL rpt_release_timeout got=none exp=release"); end
            n_checks++;
            for (int k = 0; k < 10; k++) begin
                cycle();
                if (rpt_a[2] !== 1'b0) begin n_errors++; $display("FAIL rpt_after_release k=%0d got=1 exp=0", k); end
                n_checks++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int pc;
        pc = -1;
        en = 1'b1;
        btn_a[3] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            if (obs !== exp_all()) begin n_errors++; $display("FAIL rstmid_model k=%0d got=%h exp=%h", k, obs, exp_all()); end
            n_checks++;
        end
        rst_n = 1'b0;
        model_clear();
        #1;
        if (obs !== 32'h0) begin n_errors++; $display("FAIL rstmid_async got=%h exp=0", obs); end
        n_checks++;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (obs !== 32'h0) begin n_errors++; $display("FAIL rstmid_hold got=%h exp=0", obs); end
            n_checks++;
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (obs !== exp_all()) begin n_errors++; $display("FAIL rstmid_after k=%0d got=%h exp=%h", k, obs, exp_all()); end
            n_checks++;
            if (prs_a[3] && pc < 0) pc = k;
        end
        if (pc !== 6) begin n_errors++; $display("FAIL rstmid_press got cyc=%0d exp=6", pc); end
        n_checks++;
    endtask

    task automatic test_active_low();
        int pc;
        logic [3:0] vb, va;
        pc = -1; vb = '0; va = '0;
        en = 1'b1;
        btn_a[0] = 1'b1;
        btn_b[3] = 1'b0;
        btn_b[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (obs !== exp_all()) begin n_errors++; $display("FAIL actlow_model k=%0d got=%h exp=%h", k, obs, exp_all()); end
            n_checks++;
            if (prs_b != 4'h0 && pc < 0) begin pc = k; vb = prs_b; va = prs_a; end
        end
        if (pc !== 6 || vb !== 4'b1001 || va !== 4'b0001) begin
            n_errors++; $display("FAIL actlow_simul got cyc=%0d b=%b a=%b exp cyc=6 b=1001 a=0001", pc, vb, va);
        end
        n_checks++;
        btn_a[0] = 1'b0;
        btn_b = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (obs !== exp_all()) begin n_errors++; $display("FAIL actlow_restore k=%0d got=%h exp=%h", k, obs, exp_all()); end
            n_checks++;
        end
    endtask

    task automatic test_random();
        int rate;
        for (int k = 0; k < 3000; k++) begin
            rate = ((k / 200) % 2 == 1) ? 30 : 4;
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, rate - 1) == 0) btn_a[c] = ~btn_a[c];
                if ($urandom_range(0, rate - 1) == 0) btn_b[c] = ~btn_b[c];
            end
            en = ($urandom_range(0, 3) != 0);
            cycle();
            if (obs !== exp_all()) begin n_errors++; $display("FAIL random k=%0d got=%h exp=%h", k, obs, exp_all()); end
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_sparse_en();
        test_repeat();
        test_reset_mid();
        test_active_low();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
